ram_8_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 8-word, 16-bit register RAM (`bram_ram_8`). It owns the RAM's `in`, `address` and `load` pins and runs one read-or-write transaction at a time from either requester. When both request together, it picks a winner by round-robin and returns a one-cycle acknowledge with read data. It sits between the RAM8 instance and two bus masters, for example a CPU data port and a DMA/debug port.

---
 rtl/ram_8_arbiter_if.sv | 13 +
 rtl/ram_8_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_8_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_8_arbiter_if.sv
// Requester-side bus for ram_8_arbiter: one instance per requester.
// A requester holds req and operands until ack; ack is a one-cycle pulse with rdata valid.
interface ram_8_arbiter_if;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_8_arbiter.sv
// Round-robin two-requester sequencer for the 8x16 register RAM (bram_ram_8).
// Optional RAM8_ARB_CLEAR_EN: after reset, zero all 8 words before accepting requests.
module ram_8_arbiter (
  input  logic               clk,
  input  logic               reset,
  ram_8_arbiter_if.slave     a,
  ram_8_arbiter_if.slave     b,
  output logic [15:0]        ram_in,
  output logic [2:0]         ram_address,
  output logic               ram_load,
  input  logic [15:0]        ram_out,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_SERVE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef RAM8_ARB_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  logic [2:0] clr_cnt;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t      state, state_nx;
  logic        rr;          // 0: A wins a tie, 1: B wins a tie
  logic        grant_a, grant_b;
  logic        lat_id;      // 0: A, 1: B
  logic        lat_we;
  logic [2:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] a_rdata_q, b_rdata_q;

  always_comb begin
    grant_a = a.req & (~b.req | ~rr);
    grant_b = b.req & (~a.req | rr);
  end

  always_comb begin
    state_nx = state;
    case (state)
`ifdef RAM8_ARB_CLEAR_EN
      S_CLEAR: if (clr_cnt == 3'd7) state_nx = S_IDLE;
`endif
      S_IDLE:  if (grant_a | grant_b) state_nx = S_SERVE;
      S_SERVE: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // RAM pins are idle (all zero) outside SERVE/CLEAR; load is killed by reset so
  // a transaction interrupted in SERVE never commits.
  always_comb begin
    ram_load    = 1'b0;
    ram_address = 3'd0;
    ram_in      = 16'd0;
    case (state)
      S_SERVE: begin
        ram_load    = lat_we;
        ram_address = lat_addr;
        ram_in      = lat_wdata;
      end
`ifdef RAM8_ARB_CLEAR_EN
      S_CLEAR: begin
        ram_load    = 1'b1;
        ram_address = clr_cnt;
      end
`endif
      default: ;
    endcase
    if (reset) ram_load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_STATE;
      rr        <= 1'b0;
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 3'd0;
      lat_wdata <= 16'd0;
      a_rdata_q <= 16'd0;
      b_rdata_q <= 16'd0;
`ifdef RAM8_ARB_CLEAR_EN
      clr_cnt   <= 3'd0;
`endif
    end else begin
      state <= state_nx;
      if (state == S_IDLE && (grant_a | grant_b)) begin
        lat_id    <= grant_b;
        lat_we    <= grant_b ? b.we    : a.we;
        lat_addr  <= grant_b ? b.addr  : a.addr;
        lat_wdata <= grant_b ? b.wdata : a.wdata;
        rr        <= ~grant_b;
      end
      // A write captures the pre-write word, since ram_out is combinational.
      if (state == S_SERVE) begin
        if (lat_id) b_rdata_q <= ram_out;
        else        a_rdata_q <= ram_out;
      end
`ifdef RAM8_ARB_CLEAR_EN
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 3'd1;
`endif
    end
  end

  always_comb begin
    a.ack     = (state == S_DONE) & ~lat_id & ~reset;
    b.ack     = (state == S_DONE) &  lat_id & ~reset;
    a.rdata   = a_rdata_q;
    b.rdata   = b_rdata_q;
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_ram_8_arbiter.sv
// Directed scoreboard bench for ram_8_arbiter with a behavioural 8x16 RAM attached.
module tb_ram_8_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_in, ram_out;
  logic [2:0]  ram_address;
  logic        ram_load, busy;
  logic [1:0]  state_dbg;

  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  ram_8_arbiter_if a_if ();
  ram_8_arbiter_if b_if ();

  ram_8_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a_if),
    .b           (b_if),
    .ram_in      (ram_in),
    .ram_address (ram_address),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // clock / environment RAM
  always #5 clk = ~clk;

  logic [15:0] mem [8];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // scoreboard
  logic [15:0] shadow [8];
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic        exp_rr;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic we, input logic [2:0] addr, input logic [15:0] wdata);
    if (id) begin
      b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
      exp_b_q.push_back(shadow[addr]);
    end else begin
      a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
      exp_a_q.push_back(shadow[addr]);
    end
    if (we) shadow[addr] = wdata;
  endtask

  task automatic drop(input logic id);
    if (id) b_if.req = 1'b0;
    else    a_if.req = 1'b0;
  endtask

  task automatic check_rdata(input string tag, input logic id);
    logic [15:0] e;
    e = 16'hxxxx;
    if (id && exp_b_q.size() > 0)       e = exp_b_q.pop_front();
    else if (!id && exp_a_q.size() > 0) e = exp_a_q.pop_front();
    check(tag, id ? b_if.rdata : a_if.rdata, e);
  endtask

  task automatic zero_shadow();
    for (int i = 0; i < 8; i++) shadow[i] = 16'd0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check(tag, busy, 1'b0);
  endtask

  // One transaction with no competitor: ack latency 2, one load cycle on writes.
  task automatic single(input string tag, input logic id, input logic we,
                        input logic [2:0] addr, input logic [15:0] wdata);
    int cyc, loads;
    logic got;
    @(negedge clk);
    drive(id, we, addr, wdata);
    cyc = 0; loads = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (ram_load) loads++;
      if (id ? b_if.ack : a_if.ack) got = 1'b1;
    end
    check({tag, "_ack"}, got, 1'b1);
    check({tag, "_latency"}, cyc[15:0], 16'd2);
    check({tag, "_loads"}, loads[15:0], {15'd0, we});
    check({tag, "_other_ack"}, id ? a_if.ack : b_if.ack, 1'b0);
    check_rdata({tag, "_rdata"}, id);
    drop(id);
    exp_rr = ~id;
  endtask

  // Both requesters hold req for n transactions in total; each reissues after its ack.
  task automatic contend(input string tag, input int n);
    int issued, done, last, cyc;
    logic exp_next, id;
    issued = 2; done = 0; last = -1; cyc = 0;
    exp_next = exp_rr;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd1, 16'($urandom_range(0, 16'hFFFF)));
    drive(1'b1, 1'b1, 3'd6, 16'($urandom_range(0, 16'hFFFF)));
    while (done < n && cyc < n * 3 + 12) begin
      @(negedge clk);
      cyc++;
      if (a_if.ack || b_if.ack) begin
        id = b_if.ack;
        check({tag, "_both_ack"}, a_if.ack & b_if.ack, 1'b0);
        check({tag, "_order"}, id, exp_next);
        if (last >= 0) check({tag, "_spacing"}, 16'(cyc - last), 16'd3);
        else           check({tag, "_first_latency"}, cyc[15:0], 16'd2);
        check_rdata({tag, "_rdata"}, id);
        last = cyc; done++;
        exp_next = ~id;
        exp_rr = ~id;
        if (issued < n) begin
          drive(id, 1'b1, id ? 3'd6 : 3'd1, 16'($urandom_range(0, 16'hFFFF)));
          issued++;
        end else begin
          drop(id);
        end
      end
    end
    check({tag, "_count"}, done[15:0], n[15:0]);
    drop(1'b0);
    drop(1'b1);
  endtask

  initial begin
    int noack;
    reset = 1'b1;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 3'd0; a_if.wdata = 16'd0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 3'd0; b_if.wdata = 16'd0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'($urandom_range(0, 16'hFFFF));
      shadow[i] = mem[i];
    end
    exp_rr = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_a_ack", a_if.ack, 1'b0);
    check("rst_b_ack", b_if.ack, 1'b0);
    check("rst_a_rdata", a_if.rdata, 16'd0);
    check("rst_b_rdata", b_if.rdata, 16'd0);
`ifdef RAM8_ARB_CLEAR_EN
    check("rst_busy", busy, 1'b1);
    check("rst_clear_addr", ram_address, 3'd0);
    wait_idle("rst_clear_done");
    zero_shadow();
`else
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_ram_load", ram_load, 1'b0);
    check("rst_ram_address", ram_address, 3'd0);
    check("rst_ram_in", ram_in, 16'd0);
`endif

    // collisions: A wins after reset, then B wins after an A grant
    contend("collide1", 2);
    single("a_read0", 1'b0, 1'b0, 3'd0, 16'd0);
    contend("collide2", 2);

    // write then read
    single("a_wr5", 1'b0, 1'b1, 3'd5, 16'h1234);
    single("a_rd5", 1'b0, 1'b0, 3'd5, 16'd0);

    // write returns old data; read-after-write sees new data
    single("a_wr2", 1'b0, 1'b1, 3'd2, 16'h00FF);
    single("b_wr2", 1'b1, 1'b1, 3'd2, 16'hBEEF);
    single("b_rd2", 1'b1, 1'b0, 3'd2, 16'd0);

    contend("contend", 12);

    // reset during DONE suppresses the ack
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 3'd7;
    repeat (2) @(negedge clk);
    check("rdone_state", state_dbg, ST_DONE);
    reset = 1'b1;
    #1;
    check("rdone_a_ack", a_if.ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    a_if.req = 1'b0;
    #1;
    wait_idle("rdone_idle");
`ifdef RAM8_ARB_CLEAR_EN
    zero_shadow();
`endif
    exp_rr = 1'b0;

    // reset during SERVE drops a write
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 3'd3; a_if.wdata = 16'hAAAA;
    @(negedge clk);
    check("rserve_state", state_dbg, ST_SERVE);
    reset = 1'b1;
    #1;
    check("rserve_load_forced", ram_load, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    a_if.req = 1'b0;
    #1;
    check("rserve_a_ack", a_if.ack, 1'b0);
    check("rserve_a_rdata", a_if.rdata, 16'd0);
    check("rserve_b_rdata", b_if.rdata, 16'd0);
`ifndef RAM8_ARB_CLEAR_EN
    check("rserve_busy", busy, 1'b0);
    check("rserve_ram_load", ram_load, 1'b0);
    check("rserve_ram_address", ram_address, 3'd0);
    check("rserve_ram_in", ram_in, 16'd0);
`endif
    noack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_if.ack) noack++;
    end
    check("rserve_no_late_ack", noack[15:0], 16'd0);
    wait_idle("rserve_idle");
`ifdef RAM8_ARB_CLEAR_EN
    zero_shadow();
`endif
    exp_rr = 1'b0;
    single("a_rd3", 1'b0, 1'b0, 3'd3, 16'd0);

`ifdef RAM8_ARB_CLEAR_EN
    // clear sequence with a request held across it
    for (int i = 0; i < 8; i++) single("preload", 1'b0, 1'b1, 3'(i), 16'hFFFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    zero_shadow();
    drive(1'b0, 1'b0, 3'd4, 16'd0);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("clr_busy", busy, 1'b1);
      check("clr_load", ram_load, 1'b1);
      check("clr_addr", ram_address, 3'(k));
      check("clr_in", ram_in, 16'd0);
      check("clr_no_ack", a_if.ack, 1'b0);
    end
    @(negedge clk);
    check("clr_idle", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("clr_held_ack", a_if.ack, 1'b1);
    check_rdata("clr_held_rdata", 1'b0);
    a_if.req = 1'b0;
    for (int i = 0; i < 8; i++) check("clr_mem_zero", mem[i], 16'd0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
